eth_rst_seq: RTL

- Reset sequencer directly downstream of the PLL clock generator; runs on the PLL output clock and consumes its synchronised lock flag.
- Filters the lock flag for stability, then holds the Ethernet PHY in hardware reset for a fixed time, waits a further settle time, and finally releases the core logic reset.
- Restarts the sequence on loss of lock or on a software reset request.
- Counts lock-loss events for debug.

---
 rtl/eth_rst_seq_if.sv | 44 ++++
 rtl/eth_rst_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/eth_rst_seq_if.sv
//------------------------------------------------------------------------------
// Module  : eth_rst_seq_if
// Purpose : Bundles the lock/request inputs and the reset/status outputs of
//           the Ethernet reset sequencer.
// Signals : pll_locked    - PLL lock flag, already synchronised to clk
//           sw_rst_req    - single-cycle software reset request
//           phy_rst_n     - active-low PHY hardware reset
//           core_rst_n    - active-low MAC/core reset
//           ready         - high only while the sequence is complete (RUN)
//           lock_loss_cnt - saturating count of lock-loss events
// Modports: slave  - the sequencer (consumes lock/request, drives resets)
//           master - the environment around it
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface eth_rst_seq_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       phy_rst_n;
  logic       core_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport slave (
    input  pll_locked,
    input  sw_rst_req,
    output phy_rst_n,
    output core_rst_n,
    output ready,
    output lock_loss_cnt
  );

  modport master (
    output pll_locked,
    output sw_rst_req,
    input  phy_rst_n,
    input  core_rst_n,
    input  ready,
    input  lock_loss_cnt
  );
endinterface

`default_nettype wire

// File: rtl/eth_rst_seq.sv
//------------------------------------------------------------------------------
// Module  : eth_rst_seq
// Purpose : Reset sequencer downstream of the PLL. Filters the lock flag for
//           stability, holds the PHY in reset for a fixed time, waits a settle
//           time, then releases the core reset. Restarts on lock loss or on a
//           software request and counts lock-loss events.
// Ports   : clk   - PLL output clock (single domain)
//           rst_n - synchronous active-low reset
//           bus   - eth_rst_seq_if.slave (pll_locked, sw_rst_req in;
//                   phy_rst_n, core_rst_n, ready, lock_loss_cnt out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eth_rst_seq #(
  parameter int LOCK_CYCLES     = 16,
  parameter int PHY_RST_CYCLES  = 500000,
  parameter int PHY_WAIT_CYCLES = 5000
) (
  input  wire              clk,
  input  wire              rst_n,
  eth_rst_seq_if.slave     bus
);

  localparam int c_MAX_12 = (LOCK_CYCLES > PHY_RST_CYCLES) ? LOCK_CYCLES : PHY_RST_CYCLES;
  localparam int c_MAX    = (c_MAX_12 > PHY_WAIT_CYCLES) ? c_MAX_12 : PHY_WAIT_CYCLES;
  localparam int CNT_W    = $clog2(c_MAX) + 1;

  localparam logic [CNT_W-1:0] c_LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  // Three-bit encoding leaves unused codes; those fall to the default branch
  // and recover to WAIT_LOCK.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'b000,
    PHY_RESET = 3'b001,
    PHY_WAIT  = 3'b010,
    RUN       = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_loss;
  logic             w_phy_rst_n_nxt;
  logic             w_core_rst_n_nxt;
  logic             r_phy_rst_n;
  logic             r_core_rst_n;
  logic             r_ready;
  logic [7:0]       r_lock_loss_cnt;

  //--------------------------------------------------------------------------
  // Next-state / counter logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss      = 1'b0;

    case (r_state)
      WAIT_LOCK: begin
        // Stability filter: any low sample restarts the count.
        // Software requests have no meaning here and are dropped.
        if (bus.pll_locked) begin
          if (r_cnt == c_LOCK_LAST) begin
            w_state_nxt = PHY_RESET;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end

      PHY_RESET, PHY_WAIT, RUN: begin
        // Lock loss outranks a coincident software request.
        if (!bus.pll_locked) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_loss      = 1'b1;
        end else if (bus.sw_rst_req) begin
          w_state_nxt = PHY_RESET;
          w_cnt_nxt   = '0;
        end else begin
          case (r_state)
            PHY_RESET: begin
              if (r_cnt == c_RST_LAST) begin
                w_state_nxt = PHY_WAIT;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
              end
            end
            PHY_WAIT: begin
              if (r_cnt == c_WAIT_LAST) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
              end
            end
            default: begin
              w_cnt_nxt = '0;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they move on
  // the same edge as the state and carry no input-to-output path.
  always_comb begin
    w_phy_rst_n_nxt  = (w_state_nxt == PHY_WAIT) || (w_state_nxt == RUN);
    w_core_rst_n_nxt = (w_state_nxt == RUN);
  end

  //--------------------------------------------------------------------------
  // State, counter and output registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= WAIT_LOCK;
      r_cnt           <= '0;
      r_phy_rst_n     <= 1'b0;
      r_core_rst_n    <= 1'b0;
      r_ready         <= 1'b0;
      r_lock_loss_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_phy_rst_n  <= w_phy_rst_n_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_ready      <= w_core_rst_n_nxt;
      if (w_loss && (r_lock_loss_cnt != 8'hFF)) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
      end
    end
  end

  assign bus.phy_rst_n     = r_phy_rst_n;
  assign bus.core_rst_n    = r_core_rst_n;
  assign bus.ready         = r_ready;
  assign bus.lock_loss_cnt = r_lock_loss_cnt;

endmodule

`default_nettype wire
